// File: rtl/seq_control_unit.sv
// Sequenced LC-3b control unit: one control word per cycle, holds it across d-cache waits,
// splits LDI/STI/TRAP into two memory micro-ops and aborts a stuck access after MEM_TIMEOUT cycles.
package seq_control_unit_pkg;
    typedef enum logic [3:0] {
        op_br, op_add, op_ldb, op_stb, op_jsr, op_and, op_ldr, op_str,
        op_rti, op_not, op_ldi, op_sti, op_jmp, op_shf, op_lea, op_trap
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
    } lc3b_aluop;

    typedef struct packed {
        lc3b_opcode opcode;
        lc3b_aluop  aluop;
        logic       load_cc;
        logic       reg_load;
        logic [1:0] pc_mux_sel;
        logic [2:0] alu_mux_sel;
        logic       dest_mux_sel;
        logic       offset_mux_sel;
        logic       sr2_mux_sel;
        logic [2:0] data_mux_sel;
        logic [1:0] wdata_mux_sel;
        logic [1:0] addr_mux_sel;
        logic       ldi_mux_sel;
        logic       br_code;
        logic       d_cache_read;
        logic       d_cache_write;
    } lc3b_control_word;
endpackage

module seq_control_unit
    import seq_control_unit_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter bit          INDIRECT_EN = 1'b1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  lc3b_opcode       opcode,
    input  logic             bit11,
    input  logic             bit5,
    input  logic             bit4,
    input  logic             mem_resp,
    output lc3b_control_word ctrl,
    output logic             stall,
    output logic             phase,
    output logic             err
);
    typedef enum logic [1:0] {S_DECODE, S_MEM_WAIT, S_IND1, S_IND2} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t           state_q, state_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d, cnt_eff;
    lc3b_opcode       op_q, op_d, cur_op;
    logic             bit11_q, bit11_d, cur_b11;
    logic             bit5_q, bit5_d, cur_b5;
    logic             bit4_q, bit4_d;
    logic             active, two_phase, is_mem, in_ph1, timeout;
    lc3b_control_word word;
    logic             unused_bit4;

    assign unused_bit4 = bit4_q;

    function automatic lc3b_control_word base_word(input lc3b_opcode op, input logic b11,
                                                   input logic b5, input logic ph1);
        lc3b_control_word w;
        w        = '0;
        w.aluop  = alu_pass;
        w.opcode = op;
        case (op)
            op_add, op_and: begin
                w.aluop    = (op == op_add) ? alu_add : alu_and;
                w.load_cc  = 1'b1;
                w.reg_load = 1'b1;
                if (b5) w.alu_mux_sel = 3'b010;
            end
            op_not: begin
                w.aluop    = alu_not;
                w.load_cc  = 1'b1;
                w.reg_load = 1'b1;
            end
            op_br: begin
                w.pc_mux_sel = 2'b01;
                w.br_code    = 1'b1;
            end
            op_jmp: w.pc_mux_sel = 2'b10;
            op_jsr: begin
                w.dest_mux_sel   = 1'b1;
                w.offset_mux_sel = 1'b1;
                w.reg_load       = 1'b1;
                w.pc_mux_sel     = b11 ? 2'b01 : 2'b10;
            end
            op_lea, op_shf: begin
                w.reg_load = 1'b1;
                w.load_cc  = 1'b1;
            end
            op_ldr: begin
                w.aluop        = alu_add;
                w.alu_mux_sel  = 3'b011;
                w.d_cache_read = 1'b1;
                w.data_mux_sel = 3'b100;
                w.reg_load     = 1'b1;
                w.load_cc      = 1'b1;
            end
            op_str: begin
                w.aluop         = alu_add;
                w.alu_mux_sel   = 3'b011;
                w.d_cache_write = 1'b1;
                w.sr2_mux_sel   = 1'b1;
                w.wdata_mux_sel = 2'b01;
            end
            op_ldi, op_sti, op_trap: begin
                if (!INDIRECT_EN) begin
                    w = '0;
                end else if (!ph1) begin
                    // first micro-op always fetches the pointer / vector entry
                    w.d_cache_read = 1'b1;
                    if (op == op_trap) begin
                        w.addr_mux_sel = 2'b10;
                    end else begin
                        w.aluop       = alu_add;
                        w.alu_mux_sel = 3'b011;
                    end
                end else if (op == op_ldi) begin
                    w.d_cache_read = 1'b1;
                    w.ldi_mux_sel  = 1'b1;
                    w.data_mux_sel = 3'b100;
                    w.reg_load     = 1'b1;
                    w.load_cc      = 1'b1;
                end else if (op == op_sti) begin
                    w.d_cache_write = 1'b1;
                    w.ldi_mux_sel   = 1'b1;
                    w.sr2_mux_sel   = 1'b1;
                    w.wdata_mux_sel = 2'b01;
                end else begin
                    w.d_cache_read = 1'b1;
                    w.pc_mux_sel   = 2'b11;
                    w.dest_mux_sel = 1'b1;
                    w.reg_load     = 1'b1;
                end
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    always_comb begin
        cur_op    = (state_q == S_DECODE) ? opcode : op_q;
        cur_b11   = (state_q == S_DECODE) ? bit11  : bit11_q;
        cur_b5    = (state_q == S_DECODE) ? bit5   : bit5_q;
        active    = (state_q != S_DECODE) || valid_in;
        in_ph1    = (state_q == S_IND2);
        two_phase = INDIRECT_EN && (cur_op inside {op_ldi, op_sti, op_trap});
        is_mem    = two_phase || (cur_op inside {op_ldr, op_str});
        // a fresh issue from DECODE counts from zero regardless of the stored count
        cnt_eff   = (state_q == S_DECODE) ? '0 : wait_cnt_q;
        timeout   = (MEM_TIMEOUT != 0) && active && is_mem && !mem_resp && (cnt_eff == TO_LAST);

        word = base_word(cur_op, cur_b11, cur_b5, in_ph1);
        if (is_mem && !mem_resp) begin
            word.reg_load = 1'b0;
            word.load_cc  = 1'b0;
        end

        ctrl  = '0;
        stall = 1'b0;
        err   = 1'b0;
        phase = 1'b0;
        if (!reset) begin
            phase = phase_q;
            if (active) begin
                ctrl = word;
                err  = timeout;
                if (is_mem && !timeout)
                    stall = (two_phase && !in_ph1) ? 1'b1 : !mem_resp;
            end
        end
    end

    always_comb begin
        state_d    = S_DECODE;
        wait_cnt_d = '0;
        op_d       = op_q;
        bit11_d    = bit11_q;
        bit5_d     = bit5_q;
        bit4_d     = bit4_q;
        if (state_q == S_DECODE && valid_in) begin
            op_d    = opcode;
            bit11_d = bit11;
            bit5_d  = bit5;
            bit4_d  = bit4;
        end
        if (active && is_mem && !timeout) begin
            if (mem_resp) begin
                state_d = (two_phase && !in_ph1) ? S_IND2 : S_DECODE;
            end else begin
                state_d    = two_phase ? (in_ph1 ? S_IND2 : S_IND1) : S_MEM_WAIT;
                wait_cnt_d = cnt_eff + 1'b1;
            end
        end
        phase_d = (state_d == S_IND2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_DECODE;
            phase_q    <= 1'b0;
            wait_cnt_q <= '0;
            op_q       <= op_br;
            bit11_q    <= 1'b0;
            bit5_q     <= 1'b0;
            bit4_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            wait_cnt_q <= wait_cnt_d;
            op_q       <= op_d;
            bit11_q    <= bit11_d;
            bit5_q     <= bit5_d;
            bit4_q     <= bit4_d;
        end
    end
endmodule

// File: tb/tb_seq_control_unit.sv
// Randomised bench for seq_control_unit: a transaction-level model walks each instruction's
// micro-ops and response delays, and a single compare process checks every cycle.
module tb_seq_control_unit;
    import seq_control_unit_pkg::*;

    localparam int TO = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1, valid_in = 1'b0, bit11 = 1'b0, bit5 = 1'b0, bit4 = 1'b0;
    logic             mem_resp = 1'b0;
    lc3b_opcode       opcode = op_br;
    lc3b_control_word ctrl;
    logic             stall, phase, err;

    seq_control_unit #(.MEM_TIMEOUT(TO), .INDIRECT_EN(1'b1), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .opcode(opcode), .bit11(bit11),
        .bit5(bit5), .bit4(bit4), .mem_resp(mem_resp), .ctrl(ctrl), .stall(stall),
        .phase(phase), .err(err)
    );

    always #5 clk = ~clk;

    int               n_vec = 0, n_bad = 0;
    bit               exp_on = 1'b0;
    lc3b_control_word exp_ctrl = '0;
    logic             exp_stall = 1'b0, exp_phase = 1'b0, exp_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            chk("ctrl", 32'(ctrl), 32'(exp_ctrl));
            chk("stall", 32'(stall), 32'(exp_stall));
            chk("phase", 32'(phase), 32'(exp_phase));
            chk("err", 32'(err), 32'(exp_err));
        end
    end

    // Control word an instruction's micro-op must carry, straight from the opcode table.
    function automatic lc3b_control_word mword(input logic [3:0] op, input logic b11,
                                               input logic b5, input int ph);
        lc3b_control_word w;
        w = '0;
        w.aluop = alu_pass;
        w.opcode = lc3b_opcode'(op);
        case (op)
            4'd1:  begin w.aluop = alu_add; w.load_cc = 1; w.reg_load = 1; if (b5) w.alu_mux_sel = 3'b010; end
            4'd5:  begin w.aluop = alu_and; w.load_cc = 1; w.reg_load = 1; if (b5) w.alu_mux_sel = 3'b010; end
            4'd9:  begin w.aluop = alu_not; w.load_cc = 1; w.reg_load = 1; end
            4'd0:  begin w.pc_mux_sel = 2'b01; w.br_code = 1; end
            4'd12: w.pc_mux_sel = 2'b10;
            4'd4:  begin w.dest_mux_sel = 1; w.offset_mux_sel = 1; w.reg_load = 1;
                         w.pc_mux_sel = b11 ? 2'b01 : 2'b10; end
            4'd13, 4'd14: begin w.reg_load = 1; w.load_cc = 1; end
            4'd6:  begin w.aluop = alu_add; w.alu_mux_sel = 3'b011; w.d_cache_read = 1;
                         w.data_mux_sel = 3'b100; w.reg_load = 1; w.load_cc = 1; end
            4'd7:  begin w.aluop = alu_add; w.alu_mux_sel = 3'b011; w.d_cache_write = 1;
                         w.sr2_mux_sel = 1; w.wdata_mux_sel = 2'b01; end
            4'd10, 4'd11, 4'd15: begin
                if (ph == 0) begin
                    w.d_cache_read = 1;
                    if (op == 4'd15) w.addr_mux_sel = 2'b10;
                    else begin w.aluop = alu_add; w.alu_mux_sel = 3'b011; end
                end else if (op == 4'd10) begin
                    w.d_cache_read = 1; w.ldi_mux_sel = 1; w.data_mux_sel = 3'b100;
                    w.reg_load = 1; w.load_cc = 1;
                end else if (op == 4'd11) begin
                    w.d_cache_write = 1; w.ldi_mux_sel = 1; w.sr2_mux_sel = 1; w.wdata_mux_sel = 2'b01;
                end else begin
                    w.d_cache_read = 1; w.pc_mux_sel = 2'b11; w.dest_mux_sel = 1; w.reg_load = 1;
                end
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    task automatic cyc(input logic rst, input logic v, input logic [3:0] op, input logic b11,
                       input logic b5, input logic b4, input logic resp, input lc3b_control_word ec,
                       input logic es, input logic ep, input logic ee);
        @(posedge clk); #1;
        reset = rst; valid_in = v; opcode = lc3b_opcode'(op);
        bit11 = b11; bit5 = b5; bit4 = b4; mem_resp = resp;
        exp_ctrl = ec; exp_stall = es; exp_phase = ep; exp_err = ee; exp_on = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            '0, 1'b0, 1'b0, 1'b0);
    endtask

    // d0/d1: cycles of delay before mem_resp per phase; abort_at: micro-op cycle index that gets reset
    task automatic run_instr(input logic [3:0] op, input logic b11, input logic b5, input logic b4,
                             input int d0, input int d1, input int abort_at,
                             input bit junk_fix, input logic [3:0] junk_op);
        bit two, mem, resp, to;
        int t;
        logic [3:0] fo;
        logic f11, f5, f4;
        lc3b_control_word w;
        two = (op == 4'd10) || (op == 4'd11) || (op == 4'd15);
        mem = two || (op == 4'd6) || (op == 4'd7);
        if (!mem) begin
            cyc(1'b0, 1'b1, op, b11, b5, b4, 1'($urandom), mword(op, b11, b5, 0), 1'b0, 1'b0, 1'b0);
            return;
        end
        t = 0;
        for (int p = 0; p < (two ? 2 : 1); p++) begin
            for (int k = 1; k <= TO; k++) begin
                resp = (k == ((p == 0) ? d0 : d1) + 1);
                to = !resp && (k == TO);
                if (t == 0) begin
                    fo = op; f11 = b11; f5 = b5; f4 = b4;
                end else begin
                    fo = junk_fix ? junk_op : 4'($urandom);
                    f11 = 1'($urandom); f5 = 1'($urandom); f4 = 1'($urandom);
                end
                if (t == abort_at) begin
                    cyc(1'b1, 1'b1, fo, f11, f5, f4, resp, '0, 1'b0, 1'b0, 1'b0);
                    return;
                end
                w = mword(op, b11, b5, p);
                if (!resp) begin w.reg_load = 0; w.load_cc = 0; end
                cyc(1'b0, (t == 0) ? 1'b1 : 1'($urandom), fo, f11, f5, f4, resp, w,
                    to ? 1'b0 : ((two && p == 0) ? 1'b1 : !resp), p[0], to);
                t++;
                if (to) return;
                if (resp) break;
            end
        end
    endtask

    initial begin
        cyc(1'b1, 1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        idle();

        run_instr(4'd1, 1'b0, 1'b1, 1'b0, 0, 0, -1, 1'b0, 4'd0);
        chk("t1_aluop", 32'(ctrl.aluop), 32'(alu_add));
        chk("t1_alumux", 32'(ctrl.alu_mux_sel), 32'(3'b010));
        chk("t1_regld", 32'(ctrl.reg_load), 32'(1'b1));
        chk("t1_stall", 32'(stall), 32'(1'b0));

        run_instr(4'd6, 1'b0, 1'b0, 1'b0, 3, 0, -1, 1'b0, 4'd0);
        chk("t2_regld", 32'(ctrl.reg_load), 32'(1'b1));
        chk("t2_stall", 32'(stall), 32'(1'b0));

        run_instr(4'd10, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0, 4'd0);
        chk("t3_phase", 32'(phase), 32'(1'b1));
        chk("t3_ldimux", 32'(ctrl.ldi_mux_sel), 32'(1'b1));
        chk("t3_regld", 32'(ctrl.reg_load), 32'(1'b1));
        idle();
        chk("t3_back", 32'(phase), 32'(1'b0));

        run_instr(4'd11, 1'b0, 1'b0, 1'b0, 2, 1, -1, 1'b1, 4'd1);
        chk("t4_write", 32'(ctrl.d_cache_write), 32'(1'b1));
        chk("t4_wdata", 32'(ctrl.wdata_mux_sel), 32'(2'b01));

        run_instr(4'd6, 1'b0, 1'b0, 1'b0, 99, 0, -1, 1'b0, 4'd0);
        chk("t5_err", 32'(err), 32'(1'b1));
        chk("t5_regld", 32'(ctrl.reg_load), 32'(1'b0));
        run_instr(4'd1, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0, 4'd0);
        chk("t5_next", 32'(ctrl.reg_load), 32'(1'b1));

        run_instr(4'd15, 1'b0, 1'b0, 1'b0, 0, 5, 2, 1'b0, 4'd0);
        idle();
        chk("t6_rd", 32'(ctrl.d_cache_read), 32'(1'b0));
        chk("t6_phase", 32'(phase), 32'(1'b0));

        for (int i = 0; i < 400; i++) begin
            run_instr(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                      ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 3)) : -1, 1'b0, 4'd0);
            repeat ($urandom_range(0, 2)) idle();
        end

        exp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_control_unit.md
Name: seq_control_unit

Overview:
Sequenced successor to the single-cycle LC-3b control ROM, sitting between decode and the execute/memory stages.
- Emits one lc3b_control_word per cycle.
- Holds the word stable across d-cache wait states.
- Splits LDI, STI and TRAP into two memory micro-ops.
- Drives stall upstream, with an optional memory-timeout abort.

Parameters:
MEM_TIMEOUT, 0, max cycles a memory micro-op waits for mem_resp; 0 disables the timeout.
INDIRECT_EN, 1, 1 sequences LDI/STI/TRAP in two phases; 0 treats them as unknown opcodes.
CNT_W, 8, wait-counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
valid_in  in  1  decode presents a new instruction this cycle
opcode  in  4  lc3b_opcode of the presented instruction
bit11  in  1  IR[11] (JSR vs JSRR)
bit5  in  1  IR[5] (immediate select)
bit4  in  1  IR[4] (reserved for SHF mode)
mem_resp  in  1  d-cache completes the current read/write this cycle
ctrl  out  lc3b_control_word  control word for the current micro-op
stall  out  1  upstream must hold and re-present the instruction
phase  out  1  0 = first micro-op, 1 = second micro-op of a two-phase op
err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Clock, reset and instruction capture
  - Single clock. Reset is synchronous and active-high.
  - Reset state: DECODE, phase=0, err=0, wait_cnt=0, latched instruction fields=0. While reset=1: ctrl=0, stall=0.
  - Reset mid-operation aborts the sequence. The next cycle issues no d_cache_read/d_cache_write, and no reg_load or load_cc ever fires for the aborted instruction.
  - Instruction fields (opcode, bit11, bit5, bit4) are latched when accepted in DECODE. Later micro-ops use only the latched copy, so upstream changes while stall=1 are ignored.
- Default control word: every field 0, aluop=alu_pass, ctrl.opcode = current opcode.
- DECODE, valid_in=0: ctrl=0, stall=0.
- DECODE, valid_in=1, non-memory op: word is combinational, same cycle, stall=0.
  - ADD/AND: aluop add/and, load_cc=1, reg_load=1; alu_mux_sel=010 when bit5=1.
  - NOT: alu_not, load_cc=1, reg_load=1.
  - BR: pc_mux_sel=01, br_code=1.
  - JMP: pc_mux_sel=10.
  - JSR: dest_mux_sel=1, offset_mux_sel=1, reg_load=1; pc_mux_sel=01 if bit11=1, else 10.
  - LEA/SHF: reg_load=1, load_cc=1.
  - Unknown opcode: ctrl=0.
- LDR/STR (single memory micro-op)
  - Word: aluop add, alu_mux_sel=011.
  - LDR adds d_cache_read=1, data_mux_sel=100, reg_load=1, load_cc=1.
  - STR adds d_cache_write=1, sr2_mux_sel=1, wdata_mux_sel=01.
  - stall = !mem_resp. reg_load/load_cc are asserted only in the cycle mem_resp=1.
  - If mem_resp=0, go to MEM_WAIT and hold the identical word until mem_resp; then return to DECODE.
- LDI/STI/TRAP when INDIRECT_EN=1
  - Phase 0 (in DECODE, then IND1 if waiting): d_cache_read=1, ldi_mux_sel=0, stall=1. TRAP uses addr_mux_sel=10; LDI/STI use aluop add, alu_mux_sel=011.
  - mem_resp in phase 0 moves to IND2 at the next edge, phase=1.
  - Phase 1, LDI: d_cache_read=1, ldi_mux_sel=1, data_mux_sel=100, reg_load=1, load_cc=1.
  - Phase 1, STI: d_cache_write=1, ldi_mux_sel=1, sr2_mux_sel=1, wdata_mux_sel=01.
  - Phase 1, TRAP: d_cache_read=1, pc_mux_sel=11, dest_mux_sel=1, reg_load=1.
  - stall = !mem_resp in phase 1. mem_resp returns to DECODE.
  - Minimum latency is 2 cycles: phase-0 and phase-1 each complete with mem_resp in their first cycle.
- Wait counter
  - wait_cnt clears whenever a memory micro-op is first issued and on mem_resp. It increments every cycle the micro-op waits without mem_resp.
- Timeout (MEM_TIMEOUT>0)
  - Fires when wait_cnt == MEM_TIMEOUT-1 and mem_resp=0, i.e. the request has been held exactly MEM_TIMEOUT cycles.
  - That cycle: err=1, reg_load=0, load_cc=0, stall=0. Next state is DECODE, phase=0.
- Simultaneous events
  - mem_resp in the timeout cycle means success, not error.
  - valid_in is ignored outside DECODE.
  - A mem_resp with no outstanding request is ignored.

Test Plan:
1. Reset, then ADD with bit5=1, valid_in=1 -> same cycle: aluop=alu_add, alu_mux_sel=010, reg_load=1, load_cc=1, stall=0.
2. LDR, mem_resp arriving 3 cycles late -> ctrl held identical for 4 cycles; stall=1,1,1,0; reg_load=1 only in cycle 4.
3. LDI, mem_resp immediate in both phases -> cycle 0: phase=0, ldi_mux_sel=0, stall=1; cycle 1: phase=1, ldi_mux_sel=1, reg_load=1, stall=0; back in DECODE on cycle 2.
4. STI with opcode input changed to ADD during phase 0 -> phase 1 still issues d_cache_write=1, wdata_mux_sel=01.
5. MEM_TIMEOUT=4, LDR with no mem_resp -> err=1 on the 4th cycle with reg_load=0; next cycle accepts a new ADD normally.
6. reset asserted during TRAP phase 1 -> next cycle ctrl=0, stall=0, phase=0, no d_cache_read.
